// File: rtl/mult_share_arb_if.sv
// Request/response bundle for mult_share_arb: two requester ports plus the result port.
interface mult_share_arb_if #(
    parameter int unsigned SIZE = 8
);
    logic                  p0_valid;
    logic                  p0_ready;
    logic [SIZE-1:0]       p0_a;
    logic [SIZE-1:0]       p0_b;
    logic                  p1_valid;
    logic                  p1_ready;
    logic [SIZE-1:0]       p1_a;
    logic [SIZE-1:0]       p1_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [2*SIZE-1:0]     rsp_data;
    logic                  busy;

    // Requester/consumer side
    modport master (
        output p0_valid, p0_a, p0_b, p1_valid, p1_a, p1_b, rsp_ready,
        input  p0_ready, p1_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    // Arbiter side
    modport slave (
        input  p0_valid, p0_a, p0_b, p1_valid, p1_a, p1_b, rsp_ready,
        output p0_ready, p1_ready, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/mult_share_arb.sv
// Two-port arbiter sharing one SIZE x SIZE unsigned multiplier with fixed LAT-cycle latency.
// Optional build macro MULT_SHARE_FIXED_PRIO_EN: port 0 always wins a tie instead of round-robin.
module mult_share_arb #(
    parameter int unsigned SIZE = 8,
    parameter int unsigned LAT  = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    mult_share_arb_if.slave       bus
);
    localparam int unsigned PW    = 2 * SIZE;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   a_q, a_d;
    logic [SIZE-1:0]   b_q, b_d;
    logic              id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [PW-1:0]     rsp_data_q, rsp_data_d;
    logic              busy_q, busy_d;
`ifndef MULT_SHARE_FIXED_PRIO_EN
    logic              last_grant_q, last_grant_d;
`endif
    logic              grant0_c, grant1_c;

    // Arbitration: a grant is only offered in IDLE and never while reset is asserted
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (rstn && state_q == IDLE) begin
`ifdef MULT_SHARE_FIXED_PRIO_EN
            grant0_c = bus.p0_valid;
            grant1_c = bus.p1_valid && !bus.p0_valid;
`else
            grant0_c = bus.p0_valid && (!bus.p1_valid || last_grant_q);
            grant1_c = bus.p1_valid && (!bus.p0_valid || !last_grant_q);
`endif
        end
    end

    // Next-state and datapath: latch on accept, count out the latency, hold result until taken
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
`ifndef MULT_SHARE_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant0_c || grant1_c) begin
                    a_d          = grant1_c ? bus.p1_a : bus.p0_a;
                    b_d          = grant1_c ? bus.p1_b : bus.p0_b;
                    id_d         = grant1_c;
`ifndef MULT_SHARE_FIXED_PRIO_EN
                    last_grant_d = grant1_c;
`endif
                    cnt_d        = '0;
                    state_d      = CALC;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LAT - 1)) begin
                    state_d     = RESP;
                    rsp_data_d  = PW'(a_q) * PW'(b_q);
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            busy_q       <= 1'b0;
`ifndef MULT_SHARE_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            busy_q       <= busy_d;
`ifndef MULT_SHARE_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.p0_ready  = grant0_c;
    assign bus.p1_ready  = grant1_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: directed scenarios plus a randomized run against a timing model.
module tb_mult_share_arb;
    localparam int unsigned SIZE = 8;
    localparam int unsigned LAT  = 2;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;
    bit   m_last = 1'b1;

    mult_share_arb_if #(.SIZE(SIZE)) bus ();

    mult_share_arb #(.SIZE(SIZE), .LAT(LAT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Expected winner when both ports request, from the arbitration rule
    function automatic bit tie_winner();
`ifdef MULT_SHARE_FIXED_PRIO_EN
        return 1'b0;
`else
        return !m_last;
`endif
    endfunction

    // Wait (bounded) for rsp_valid; n = edges elapsed since the accept edge
    task automatic wait_rsp(output int n);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        bus.p0_valid = 1'b1; bus.p0_a = 8'd5; bus.p0_b = 8'd6;
        bus.p1_valid = 1'b1; bus.p1_a = 8'd7; bus.p1_b = 8'd9;
        bus.rsp_ready = 1'b1;
        rstn = 1'b0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            total++;
            if ({bus.rsp_valid, bus.busy, bus.p0_ready, bus.p1_ready} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_outs: got %b exp 0000", {bus.rsp_valid, bus.busy, bus.p0_ready, bus.p1_ready});
            end
            total++;
            if ({bus.rsp_id, bus.rsp_data} !== 17'd0) begin
                bad++;
                $display("FAIL reset_rsp: got id=%b data=%h exp 0/0000", bus.rsp_id, bus.rsp_data);
            end
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.p0_ready, bus.p1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL reset_first_grant: got %b exp 10", {bus.p0_ready, bus.p1_ready});
        end
        @(posedge clk); #1;
        bus.p0_valid = 1'b0;
        m_last = 1'b0;
        wait_rsp(n);
        total++;
        if (n != LAT || bus.rsp_id !== 1'b0 || bus.rsp_data !== 16'd30) begin
            bad++;
            $display("FAIL reset_op0: got lat=%0d id=%b data=%0d exp lat=%0d id=0 data=30", n, bus.rsp_id, bus.rsp_data, LAT);
        end
        @(posedge clk); #1;
        total++;
        if ({bus.rsp_valid, bus.p0_ready, bus.p1_ready} !== 3'b001) begin
            bad++;
            $display("FAIL reset_next_accept: got %b exp 001", {bus.rsp_valid, bus.p0_ready, bus.p1_ready});
        end
        @(posedge clk); #1;
        bus.p1_valid = 1'b0;
        m_last = 1'b1;
        wait_rsp(n);
        total++;
        if (n != LAT || bus.rsp_id !== 1'b1 || bus.rsp_data !== 16'd63) begin
            bad++;
            $display("FAIL reset_op1: got lat=%0d id=%b data=%0d exp lat=%0d id=1 data=63", n, bus.rsp_id, bus.rsp_data, LAT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        int n;
        bit w;
        logic [15:0] exp_d;
        bus.rsp_ready = 1'b1;
        bus.p0_valid = 1'b1; bus.p0_a = 8'd3;  bus.p0_b = 8'd4;
        bus.p1_valid = 1'b1; bus.p1_a = 8'd10; bus.p1_b = 8'd12;
        for (int r = 0; r < 4; r++) begin
            w = tie_winner();
            @(negedge clk);
            total++;
            if ({bus.p0_ready, bus.p1_ready} !== (w ? 2'b01 : 2'b10)) begin
                bad++;
                $display("FAIL contention_grant[%0d]: got %b exp port %0d", r, {bus.p0_ready, bus.p1_ready}, w);
            end
            @(posedge clk); #1;
            if (w) begin
                exp_d = 16'(int'(bus.p1_a) * int'(bus.p1_b));
                bus.p1_a = 8'($urandom); bus.p1_b = 8'($urandom);
            end else begin
                exp_d = 16'(int'(bus.p0_a) * int'(bus.p0_b));
                bus.p0_a = 8'($urandom); bus.p0_b = 8'($urandom);
            end
            m_last = w;
            wait_rsp(n);
            total++;
            if (n != LAT || bus.rsp_id !== w || bus.rsp_data !== exp_d) begin
                bad++;
                $display("FAIL contention_rsp[%0d]: got lat=%0d id=%b data=%h exp lat=%0d id=%b data=%h",
                         r, n, bus.rsp_id, bus.rsp_data, LAT, w, exp_d);
            end
            @(negedge clk);
            total++;
            if ({bus.p0_ready, bus.p1_ready} !== 2'b00) begin
                bad++;
                $display("FAIL contention_resp_ready[%0d]: got %b exp 00", r, {bus.p0_ready, bus.p1_ready});
            end
            @(posedge clk); #1;
        end
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
    endtask

    task automatic test_single();
        int n;
        bus.rsp_ready = 1'b1;
        bus.p0_valid = 1'b1; bus.p0_a = 8'd13; bus.p0_b = 8'd11;
        @(negedge clk);
        total++;
        if ({bus.p0_ready, bus.p1_ready, bus.busy} !== 3'b100) begin
            bad++;
            $display("FAIL single_accept: got %b exp 100", {bus.p0_ready, bus.p1_ready, bus.busy});
        end
        @(posedge clk); #1;
        m_last = 1'b0;
        total++;
        if ({bus.p0_ready, bus.busy} !== 2'b01) begin
            bad++;
            $display("FAIL single_ready_pulse: got %b exp 01", {bus.p0_ready, bus.busy});
        end
        bus.p0_valid = 1'b0;
        wait_rsp(n);
        total++;
        if (n != LAT || bus.rsp_id !== 1'b0 || bus.rsp_data !== 16'd143) begin
            bad++;
            $display("FAIL single_rsp: got lat=%0d id=%b data=%0d exp lat=%0d id=0 data=143", n, bus.rsp_id, bus.rsp_data, LAT);
        end
        @(posedge clk); #1;
        total++;
        if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
            bad++;
            $display("FAIL single_done: got %b exp 00", {bus.rsp_valid, bus.busy});
        end
    endtask

    task automatic test_width();
        int n;
        bit          port [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0]  av   [3] = '{8'd255, 8'd0, 8'd200};
        logic [7:0]  bv   [3] = '{8'd255, 8'd200, 8'd3};
        logic [15:0] ev   [3] = '{16'hFE01, 16'd0, 16'd600};
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (port[k]) begin
                bus.p1_valid = 1'b1; bus.p1_a = av[k]; bus.p1_b = bv[k];
            end else begin
                bus.p0_valid = 1'b1; bus.p0_a = av[k]; bus.p0_b = bv[k];
            end
            @(negedge clk);
            total++;
            if ({bus.p0_ready, bus.p1_ready} !== (port[k] ? 2'b01 : 2'b10)) begin
                bad++;
                $display("FAIL width_grant[%0d]: got %b exp port %0d", k, {bus.p0_ready, bus.p1_ready}, port[k]);
            end
            @(posedge clk); #1;
            bus.p0_valid = 1'b0;
            bus.p1_valid = 1'b0;
            m_last = port[k];
            wait_rsp(n);
            total++;
            if (n != LAT || bus.rsp_id !== port[k] || bus.rsp_data !== ev[k]) begin
                bad++;
                $display("FAIL width_rsp[%0d]: got lat=%0d id=%b data=%h exp lat=%0d id=%b data=%h",
                         k, n, bus.rsp_id, bus.rsp_data, LAT, port[k], ev[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int n;
        bus.rsp_ready = 1'b0;
        bus.p0_valid = 1'b1; bus.p0_a = 8'd17; bus.p0_b = 8'd3;
        @(posedge clk); #1;
        m_last = 1'b0;
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b1; bus.p1_a = 8'd9; bus.p1_b = 8'd9;
        wait_rsp(n);
        total++;
        if (n != LAT) begin
            bad++;
            $display("FAIL bp_latency: got %0d exp %0d", n, LAT);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.p0_ready, bus.p1_ready, bus.busy} !==
                {1'b1, 1'b0, 16'd51, 1'b0, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%b d=%0d r0=%b r1=%b busy=%b exp v=1 id=0 d=51 r0=0 r1=0 busy=1",
                         i, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.p0_ready, bus.p1_ready, bus.busy);
            end
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, bus.p1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL bp_handshake_cycle: got %b exp 10", {bus.rsp_valid, bus.p1_ready});
        end
        @(posedge clk); @(negedge clk);
        total++;
        if ({bus.rsp_valid, bus.p1_ready} !== 2'b01) begin
            bad++;
            $display("FAIL bp_p1_accept: got %b exp 01", {bus.rsp_valid, bus.p1_ready});
        end
        @(posedge clk); #1;
        bus.p1_valid = 1'b0;
        m_last = 1'b1;
        wait_rsp(n);
        total++;
        if (n != LAT || bus.rsp_id !== 1'b1 || bus.rsp_data !== 16'd81) begin
            bad++;
            $display("FAIL bp_p1_rsp: got lat=%0d id=%b data=%0d exp lat=%0d id=1 data=81", n, bus.rsp_id, bus.rsp_data, LAT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n;
        bus.rsp_ready = 1'b1;
        bus.p0_valid = 1'b1; bus.p0_a = 8'd21; bus.p0_b = 8'd2;
        @(posedge clk); #1;
        bus.p0_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        m_last = 1'b1;
        for (int i = 0; i < int'(LAT) + 3; i++) begin
            @(negedge clk);
            total++;
            if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
                bad++;
                $display("FAIL midreset_quiet[%0d]: got %b exp 00", i, {bus.rsp_valid, bus.busy});
            end
            @(posedge clk); #1;
        end
        bus.p0_valid = 1'b1; bus.p0_a = 8'd6;  bus.p0_b = 8'd7;
        bus.p1_valid = 1'b1; bus.p1_a = 8'd8;  bus.p1_b = 8'd8;
        @(negedge clk);
        total++;
        if ({bus.p0_ready, bus.p1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL midreset_tie: got %b exp 10", {bus.p0_ready, bus.p1_ready});
        end
        @(posedge clk); #1;
        bus.p0_valid = 1'b0;
        m_last = 1'b0;
        wait_rsp(n);
        total++;
        if (n != LAT || bus.rsp_id !== 1'b0 || bus.rsp_data !== 16'd42) begin
            bad++;
            $display("FAIL midreset_rsp: got lat=%0d id=%b data=%0d exp lat=%0d id=0 data=42", n, bus.rsp_id, bus.rsp_data, LAT);
        end
        @(posedge clk); #1;
        bus.p1_valid = 1'b0;
    endtask

    // Randomized requesters and consumer checked against an op-in-flight timing model
    task automatic test_random(input int ncyc);
        bit          inflight = 1'b0;
        int          age = 0;
        bit          fid = 1'b0;
        logic [15:0] fdata = '0;
        bit          w0, w1, exp_rv;
        for (int c = 0; c < ncyc; c++) begin
            if (!bus.p0_valid && $urandom_range(0, 2) == 0) begin
                bus.p0_valid = 1'b1; bus.p0_a = 8'($urandom); bus.p0_b = 8'($urandom);
            end
            if (!bus.p1_valid && $urandom_range(0, 2) == 0) begin
                bus.p1_valid = 1'b1; bus.p1_a = 8'($urandom); bus.p1_b = 8'($urandom);
            end
            bus.rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            w0 = 1'b0;
            w1 = 1'b0;
            if (!inflight) begin
                if (bus.p0_valid && bus.p1_valid) begin
                    w1 = tie_winner();
                    w0 = !w1;
                end else begin
                    w0 = bus.p0_valid;
                    w1 = bus.p1_valid;
                end
            end
            exp_rv = inflight && (age >= int'(LAT));
            total++;
            if ({bus.p0_ready, bus.p1_ready, bus.rsp_valid, bus.busy} !== {w0, w1, exp_rv, inflight}) begin
                bad++;
                $display("FAIL rand_ctrl[%0d]: got r0r1vb=%b exp %b", c,
                         {bus.p0_ready, bus.p1_ready, bus.rsp_valid, bus.busy}, {w0, w1, exp_rv, inflight});
            end
            if (exp_rv) begin
                total++;
                if (bus.rsp_id !== fid || bus.rsp_data !== fdata) begin
                    bad++;
                    $display("FAIL rand_rsp[%0d]: got id=%b data=%h exp id=%b data=%h", c, bus.rsp_id, bus.rsp_data, fid, fdata);
                end
            end
            @(posedge clk); #1;
            if (w0 || w1) begin
                inflight = 1'b1;
                age      = 0;
                fid      = w1;
                fdata    = w1 ? 16'(int'(bus.p1_a) * int'(bus.p1_b)) : 16'(int'(bus.p0_a) * int'(bus.p0_b));
                m_last   = w1;
                if (w1) bus.p1_valid = 1'b0;
                else    bus.p0_valid = 1'b0;
            end else if (inflight) begin
                if (exp_rv && bus.rsp_ready) inflight = 1'b0;
                else                         age++;
            end
        end
    endtask

    initial begin
        bus.p0_valid = 1'b0; bus.p0_a = '0; bus.p0_b = '0;
        bus.p1_valid = 1'b0; bus.p1_a = '0; bus.p1_b = '0;
        bus.rsp_ready = 1'b0;
        rstn = 1'b0;
        test_reset();
        test_contention();
        test_single();
        test_width();
        test_backpressure();
        test_reset_mid();
        test_random(400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
